// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

    localparam int WB_XLEN    = 64;
    localparam int NUM_WB_SRC = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_MDU = 1;
    localparam int SRC_FPU = 2;

    localparam logic REG_INT   = 1'b0;
    localparam logic REG_FLOAT = 1'b1;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_type;
        logic [63:0] data;
    } wb_req_t;

    // Integer x0 is hardwired to zero, so writes to it are dropped.
    function automatic logic is_x0(input wb_req_t req);
        return (req.reg_type == REG_INT) && (req.rd == 5'd0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; full/empty come from registered pointers only.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_req_t     mem [DEPTH];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, round-robin grant, registered register-file write port.
// Optional operand forwarding from the output register is enabled by defining WB_BYPASS_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = NUM_WB_SRC,
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = WB_XLEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC-1:0][4:0]       src_rd,
    input  logic [NUM_SRC-1:0]            src_reg_type,
    input  logic [NUM_SRC-1:0][XLEN-1:0]  src_data,
    output logic [4:0]                    rd_wb,
    output logic                          reg_type_wb,
    output logic [XLEN-1:0]               op_wb,
    output logic                          we_rd_wb,
`ifdef WB_BYPASS_EN
    input  logic [4:0]                    rs1_dec,
    input  logic [4:0]                    rs2_dec,
    input  logic [4:0]                    rs3_dec,
    input  logic                          reg_type_dec,
    input  logic [XLEN-1:0]               op1_rf,
    input  logic [XLEN-1:0]               op2_rf,
    input  logic [XLEN-1:0]               op3_rf,
    output logic [XLEN-1:0]               op1_fwd,
    output logic [XLEN-1:0]               op2_fwd,
    output logic [XLEN-1:0]               op3_fwd,
`endif
    output logic [NUM_SRC-1:0]            pending
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_req_t              push_req [NUM_SRC];
    wb_req_t              head     [NUM_SRC];
    logic [NUM_SRC-1:0]   push;
    logic [NUM_SRC-1:0]   pop;
    logic [NUM_SRC-1:0]   full;
    logic [NUM_SRC-1:0]   empty;

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant_idx;
    logic                 grant_valid;
    wb_req_t              granted;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign push_req[s] = '{rd:       src_rd[s],
                               reg_type: src_reg_type[s],
                               data:     WB_XLEN'(src_data[s])};
        assign push[s]     = src_valid[s] && !full[s];

        wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[s]),
            .push_data (push_req[s]),
            .pop       (pop[s]),
            .head      (head[s]),
            .full      (full[s]),
            .empty     (empty[s])
        );
    end

    assign src_ready = ~full;
    assign pending   = ~empty;

    // Scan sources starting at the round-robin pointer, wrapping once.
    always_comb begin
        int            cand;
        logic [PW-1:0] cidx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cidx        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_SRC)
                cand = cand - NUM_SRC;
            cidx = PW'(cand);
            if (!grant_valid && !empty[cidx]) begin
                grant_valid = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid)
            pop[grant_idx] = 1'b1;
    end

    assign granted = head[grant_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            rd_wb       <= '0;
            reg_type_wb <= 1'b0;
            op_wb       <= '0;
            we_rd_wb    <= 1'b0;
        end else if (grant_valid) begin
            rr_ptr      <= (grant_idx == PW'(NUM_SRC - 1)) ? '0 : grant_idx + PW'(1);
            rd_wb       <= granted.rd;
            reg_type_wb <= granted.reg_type;
            op_wb       <= XLEN'(granted.data);
            we_rd_wb    <= !is_x0(granted);
        end else begin
            we_rd_wb    <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle to decode operands that read the same register.
    logic wb_hit_type;

    assign wb_hit_type = we_rd_wb && (reg_type_wb == reg_type_dec);
    assign op1_fwd     = (wb_hit_type && (rd_wb == rs1_dec)) ? op_wb : op1_rf;
    assign op2_fwd     = (wb_hit_type && (rd_wb == rs2_dec)) ? op_wb : op2_rf;
    assign op3_fwd     = (wb_hit_type && (rd_wb == rs3_dec)) ? op_wb : op3_rf;
`endif

endmodule
